// File: rtl/fifo_frame_packer_pkg.sv
// Shared state type and header-word helper for the write-side frame packer.
package fifo_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, HDR, DRAIN} pack_state_t;

    // Truncation flag position for the default 8-bit word; parameterised users pass width-1.
    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned HDR_TRUNC_BIT = DEF_WIDTH - 1;
    localparam int unsigned HDR_MAXW      = 64;

    // Header word: len_m1 in the low lenw bits, trunc flag in the top bit, zeros elsewhere.
    function automatic logic [HDR_MAXW-1:0] make_hdr(
        input int unsigned width,
        input int unsigned lenw,
        input int unsigned len_m1,
        input logic        trunc
    );
        logic [HDR_MAXW-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < lenw; i++) begin
            w[i] = len_m1[i];
        end
        w[width-1] = trunc;
        return w;
    endfunction

endpackage

// File: rtl/fifo_frame_packer_if.sv
// Input word stream plus async-FIFO write port, bundled for the frame packer.
interface fifo_frame_packer_if #(
    parameter int unsigned width = 8
);
    logic [width-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [width-1:0] wdata;
    logic             winc;
    logic             wfull;

    // master is the packer; slave is the stream source / FIFO side.
    modport master (
        input  s_data, s_valid, s_last, wfull,
        output s_ready, wdata, winc
    );

    modport slave (
        output s_data, s_valid, s_last, wfull,
        input  s_ready, wdata, winc
    );
endinterface

// File: rtl/fifo_frame_packer_frame_buf.sv
// Frame staging store: one synchronous write port, asynchronous read, no reset.
module frame_buf #(
    parameter int unsigned width  = 8,
    parameter int unsigned maxlen = 16,
    localparam int unsigned lenw  = $clog2(maxlen)
) (
    input  logic             wclk,
    input  logic             we,
    input  logic [lenw-1:0]  waddr,
    input  logic [width-1:0] wd,
    input  logic [lenw-1:0]  raddr,
    output logic [width-1:0] rd
);
    logic [width-1:0] mem [maxlen];

    always_ff @(posedge wclk) begin
        if (we) begin
            mem[waddr] <= wd;
        end
    end

    assign rd = mem[raddr];
endmodule

// File: rtl/fifo_frame_packer.sv
// Write-side frame packer: stages one frame, then writes a length/trunc header and the payload to the async FIFO.
module fifo_frame_packer
    import fifo_pkg::*;
#(
    parameter int unsigned width  = 8,
    parameter int unsigned maxlen = 16,
    parameter int unsigned cntw   = 16
) (
    input  logic                wclk,
    input  logic                rrst_n,
    fifo_frame_packer_if.master bus,
    output logic                busy,
    output logic [cntw-1:0]     frames_sent,
    output logic [cntw-1:0]     trunc_cnt
);
    localparam int unsigned lenw = $clog2(maxlen);

    if (lenw > width - 1) begin : g_bad_lenw
        $error("fifo_frame_packer: clog2(maxlen) must not exceed width-1");
    end
    if (maxlen < 2 || (maxlen & (maxlen - 1)) != 0) begin : g_bad_maxlen
        $error("fifo_frame_packer: maxlen must be a power of 2 and at least 2");
    end
    if (width > HDR_MAXW) begin : g_bad_width
        $error("fifo_frame_packer: width exceeds header helper range");
    end

    localparam logic [lenw:0]   MAXLEN_C = (lenw+1)'(maxlen);
    localparam logic [lenw:0]   CNT_ONE  = (lenw+1)'(1);
    localparam logic [lenw-1:0] IDX_ONE  = lenw'(1);
    localparam logic [cntw-1:0] STAT_ONE = cntw'(1);

    pack_state_t      state;
    logic [lenw:0]    wr_cnt;
    logic [lenw-1:0]  rd_idx;
    logic [lenw-1:0]  last_idx;
    logic [lenw-1:0]  waddr;
    logic             trunc;
    logic             accept;
    logic             winc_i;
    logic             buf_we;
    logic [width-1:0] buf_rdata;

    assign bus.s_ready = (state == IDLE) || (state == COLLECT);
    assign accept      = bus.s_valid && bus.s_ready;
    assign winc_i      = ((state == HDR) || (state == DRAIN)) && !bus.wfull;
    assign bus.winc    = winc_i;
    assign busy        = (state != IDLE);

    // wr_cnt is at least 1 outside IDLE/COLLECT, so the truncating subtract is the last stored index.
    assign last_idx = lenw'(wr_cnt - CNT_ONE);

    // Over-length beats are still accepted (so s_last is seen) but never reach the store.
    assign buf_we = accept && ((state == IDLE) || (wr_cnt < MAXLEN_C));
    assign waddr  = (state == IDLE) ? '0 : lenw'(wr_cnt);

    frame_buf #(
        .width  (width),
        .maxlen (maxlen)
    ) u_frame_buf (
        .wclk  (wclk),
        .we    (buf_we),
        .waddr (waddr),
        .wd    (bus.s_data),
        .raddr (rd_idx),
        .rd    (buf_rdata)
    );

    always_comb begin
        bus.wdata = '0;
        case (state)
            HDR:     bus.wdata = width'(make_hdr(width, lenw, 32'(last_idx), trunc));
            DRAIN:   bus.wdata = buf_rdata;
            default: bus.wdata = '0;
        endcase
    end

    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_idx      <= '0;
            trunc       <= 1'b0;
            frames_sent <= '0;
            trunc_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_cnt <= CNT_ONE;
                        state  <= bus.s_last ? HDR : COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (wr_cnt < MAXLEN_C) begin
                            wr_cnt <= wr_cnt + CNT_ONE;
                        end else begin
                            trunc <= 1'b1;
                        end
                        if (bus.s_last) begin
                            state <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (winc_i) begin
                        rd_idx <= '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (winc_i) begin
                        if (rd_idx != last_idx) begin
                            rd_idx <= rd_idx + IDX_ONE;
                        end else begin
                            state       <= IDLE;
                            frames_sent <= frames_sent + STAT_ONE;
                            if (trunc) begin
                                trunc_cnt <= trunc_cnt + STAT_ONE;
                            end
                            trunc <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_no_write_when_full: assert property (@(posedge wclk) disable iff (!rrst_n)
        bus.wfull |-> !winc_i);
    a_wr_cnt_range: assert property (@(posedge wclk) disable iff (!rrst_n)
        wr_cnt <= MAXLEN_C);

endmodule

// File: doc/fifo_frame_packer.md
Name: fifo_frame_packer

Overview:
- Upstream write-side stage of the async FIFO.
- Accepts a valid/ready word stream delimited by s_last and stages each frame in a local buffer.
- Writes the frame into the async FIFO write port as one header word (length and truncation flag) followed by the payload words.
- The read side can then pop whole frames knowing their length up front.

Parameters:
- width, 8, data word width; must match the FIFO width.
- maxlen, 16, maximum payload words per frame; power of 2, at least 2.
- cntw, 16, width of the statistics counters.
- Derived: lenw = $clog2(maxlen). Elaboration error unless lenw <= width-1.

Ports:
- wclk  in  1  clock; all logic is on posedge.
- rrst_n  in  1  reset, asynchronous, active-low.
- s_data  in  width  input stream word.
- s_valid  in  1  s_data is valid.
- s_last  in  1  current word is the last of the frame.
- s_ready  out  1  block accepts a word this cycle.
- wdata  out  width  word to the FIFO write port.
- winc  out  1  FIFO write strobe.
- wfull  in  1  FIFO full flag, registered in the write domain.
- busy  out  1  high in every state except IDLE.
- frames_sent  out  cntw  count of frames fully written; wraps.
- trunc_cnt  out  cntw  count of frames that were truncated; wraps.

Behaviour:
- Clock wclk; reset rrst_n, asynchronous, active-low.
- Reset values:
  - state = IDLE; wr_cnt, rd_idx, trunc flag and both counters = 0.
  - winc = 0, wdata = 0, busy = 0.
  - Buffer contents are not reset.
- A beat is accepted when s_valid && s_ready at posedge.
- winc = (state==HDR || state==DRAIN) && !wfull, combinational from registered state and wfull. It never asserts while wfull=1.
- wdata is 0 outside HDR/DRAIN.
- States:
  - IDLE: s_ready=1. An accepted beat goes to buf[0] and sets wr_cnt=1. If s_last → HDR, else → COLLECT.
  - COLLECT: s_ready=1. An accepted beat with wr_cnt<maxlen goes to buf[wr_cnt] and wr_cnt++. An accepted beat with wr_cnt==maxlen is dropped and sets the trunc flag. An accepted beat with s_last → HDR.
  - HDR: s_ready=0.
    - wdata[lenw-1:0] = wr_cnt-1; wdata[width-1] = trunc flag; all other bits 0.
    - On winc → DRAIN with rd_idx=0.
  - DRAIN: s_ready=0; wdata = buf[rd_idx].
    - On winc with rd_idx != wr_cnt-1: rd_idx++.
    - On winc with rd_idx == wr_cnt-1: → IDLE, frames_sent++, trunc_cnt++ if the trunc flag is set, trunc flag cleared.
- Latency:
  - Header winc is asserted in the cycle after the s_last beat is accepted, if wfull=0.
  - With wfull=0, a frame of L stored words produces L+1 consecutive winc cycles.
  - The next frame's first beat can be accepted in the cycle after the final payload write.
- Back-pressure: while wfull=1 in HDR/DRAIN, state, rd_idx and wdata hold. No word is lost or duplicated.
- A wr_cnt of maxlen encodes in the header as maxlen-1 (all ones in lenw bits).
- s_last on a dropped (over-length) beat still ends the frame.
- Reset mid-operation: winc deasserts asynchronously and the partial frame is discarded. No partial header is issued after release.
- Counters wrap modulo 2^cntw.

Decomposition:
- Package fifo_pkg holds:
  - typedef enum logic [1:0] {IDLE, COLLECT, HDR, DRAIN} pack_state_t.
  - Constant HDR_TRUNC_BIT = width-1.
  - A function that builds the header word from (len, trunc).
- Sub-module frame_buf: maxlen x width storage with one synchronous write port on wclk and an asynchronous read port; no reset.
- FSM, counters and the FIFO handshake stay in fifo_frame_packer.

Test Plan:
- 3-word frame 0xA1, 0xB2, 0xC3 (s_last on 0xC3), wfull=0 → winc high 4 consecutive cycles starting the cycle after 0xC3 is accepted; wdata 0x02, 0xA1, 0xB2, 0xC3; frames_sent=1; busy low afterwards.
- Single beat 0x5A with s_valid and s_last in IDLE → writes 0x00 then 0x5A; s_ready=0 for exactly those 2 cycles.
- wfull forced high for 5 cycles after the second payload write of a 4-word frame → winc=0 and wdata held for those 5 cycles; remaining 2 words then written in order; total 5 writes.
- maxlen=16, 20-word frame 0x00..0x13 → header 0x8F, payload 0x00..0x0F only; trunc_cnt=1; frames_sent=1.
- rrst_n pulsed low during DRAIN → winc drops immediately; counters=0; state IDLE; next 2-word frame 0x11, 0x22 writes exactly 0x01, 0x11, 0x22.
- s_valid held high across two back-to-back 2-word frames with wfull=0 → s_ready low during HDR/DRAIN; the second frame's first beat is accepted the cycle after the first frame's last write; 6 FIFO writes total; frames_sent=2.
